// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: instruction layout, fetch FSM states, decoded fields.
// FETCH_SINGLE_STEP_EN adds the StWaitStep state used by single-step fetch.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned INSTR_W = 12;

  localparam int unsigned OPCODE_MSB = 11;
  localparam int unsigned OPCODE_LSB = 9;
  localparam int unsigned RA_MSB     = 8;
  localparam int unsigned RA_LSB     = 6;
  localparam int unsigned IMM_MSB    = 5;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [2:0] HALT_OPCODE = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StCapt,
    StIssue,
    StHalt
`ifdef FETCH_SINGLE_STEP_EN
    ,
    StWaitStep
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] ra;
    logic [5:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read port plus the decoded-instruction handshake toward execute.
interface fetch_sequencer_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]  mem_index;
  logic [INSTR_W-1:0] mem_data;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               instr_valid;
  logic               instr_ready;
  logic [2:0]         instr_opcode;
  logic [2:0]         instr_ra;
  logic [5:0]         instr_imm;
  logic [ADDR_W-1:0]  instr_pc;

  // Fetch side.
  modport master (
    output mem_index, instr_valid, instr_opcode, instr_ra, instr_imm, instr_pc,
    input  mem_data, branch_valid, branch_target, instr_ready
  );

  // Memory/execute side.
  modport slave (
    input  mem_index, instr_valid, instr_opcode, instr_ra, instr_imm, instr_pc,
    output mem_data, branch_valid, branch_target, instr_ready
  );

endinterface

// File: rtl/instr_decode.sv
// Combinational split of a raw instruction word into opcode / ra / imm fields.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output instr_fields_t      fields
);

  always_comb begin
    fields.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    fields.ra     = instr[RA_MSB:RA_LSB];
    fields.imm    = instr[IMM_MSB:IMM_LSB];
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch FSM feeding decoded instructions to execute.
// Optional FETCH_SINGLE_STEP_EN adds step_mode/step and a wait-for-step state.
module fetch_sequencer
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mem_load,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic step_mode,
  input  logic step,
`endif
  output logic halted,
  fetch_sequencer_if.master bus
);

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  instr_fields_t      fields;

  instr_decode u_decode (
    .instr  (ir_q),
    .fields (fields)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    // A load rewrites memory underneath us, so any in-flight fetch is stale.
    if (mem_load && (state_q != StIdle)) begin
      state_d = StIdle;
      pc_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !mem_load) begin
            state_d = StAddr;
            pc_d    = '0;
          end
        end
        StAddr: state_d = StCapt;
        StCapt: begin
          ir_d    = bus.mem_data;
          state_d = StIssue;
        end
        StIssue: begin
          if (bus.instr_ready) begin
            if (fields.opcode == HALT_OPCODE) begin
              state_d = StHalt;
            end else begin
              pc_d    = bus.branch_valid ? bus.branch_target : pc_q + 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
              state_d = step_mode ? StWaitStep : StAddr;
`else
              state_d = StAddr;
`endif
            end
          end
        end
        StHalt: begin
          if (start) begin
            state_d = StAddr;
            pc_d    = '0;
          end
        end
`ifdef FETCH_SINGLE_STEP_EN
        StWaitStep: begin
          if (step) state_d = StAddr;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.mem_index    = pc_q;
  assign bus.instr_valid  = (state_q == StIssue);
  assign bus.instr_opcode = fields.opcode;
  assign bus.instr_ra     = fields.ra;
  assign bus.instr_imm    = fields.imm;
  assign bus.instr_pc     = pc_q;
  assign halted           = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a transaction-level reference model and
// a registered-read instruction memory model.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic mem_load = 1'b0;
  logic halted;
`ifdef FETCH_SINGLE_STEP_EN
  logic step_mode = 1'b0;
  logic step = 1'b0;
`endif

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_load  (mem_load),
`ifdef FETCH_SINGLE_STEP_EN
    .step_mode (step_mode),
    .step      (step),
`endif
    .halted    (halted),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [8];
  always @(posedge clk) bus.mem_data <= mem[bus.mem_index];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: running/halted flags, pc, and cycles left until the next issue.
  bit         live = 1'b0;
  bit         m_run = 1'b0;
  bit         m_halt = 1'b0;
  logic [2:0] m_pc = 3'd0;
  int         m_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      live = 1'b1; m_run = 1'b0; m_halt = 1'b0; m_pc = 3'd0; m_cnt = 0;
    end else if (live) begin
      if (mem_load) begin
        m_run = 1'b0; m_halt = 1'b0; m_pc = 3'd0;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1'b1; m_halt = 1'b0; m_pc = 3'd0; m_cnt = 2;
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
      end else if (bus.instr_ready) begin
        if (mem[m_pc][11:9] == 3'b111) begin
          m_run = 1'b0; m_halt = 1'b1;
        end else begin
          m_pc  = bus.branch_valid ? bus.branch_target : m_pc + 3'd1;
          m_cnt = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live && !reset) begin
      check("model_mem_index", bus.mem_index, m_pc);
      check("model_valid", bus.instr_valid, m_run && m_cnt == 0);
      check("model_halted", halted, m_halt);
      if (m_run && m_cnt == 0) begin
        check("model_opcode", bus.instr_opcode, mem[m_pc][11:9]);
        check("model_ra", bus.instr_ra, mem[m_pc][8:6]);
        check("model_imm", bus.instr_imm, mem[m_pc][5:0]);
        check("model_instr_pc", bus.instr_pc, m_pc);
      end
    end
  end

  task automatic wait_valid();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.instr_valid) break;
      n++;
      if (n > 12) begin
        errors++;
        $display("FAIL wait_valid: got no instr_valid expected within 12 cycles");
        break;
      end
    end
    #1;
  endtask

  task automatic accept(input logic [2:0] exp_pc, input logic bv, input logic [2:0] tgt);
    wait_valid();
    check("accept_pc", bus.instr_pc, exp_pc);
    bus.instr_ready = 1'b1; bus.branch_valid = bv; bus.branch_target = tgt;
    @(negedge clk); #1;
    bus.instr_ready = 1'b0; bus.branch_valid = 1'b0;
  endtask

  initial begin
    int first;
    bus.instr_ready = 1'b0; bus.branch_valid = 1'b0; bus.branch_target = 3'd0;
    // Program A: word i has opcode i, ra 7-i, imm 9*i+1.
    for (int i = 0; i < 8; i++) mem[i] = {3'(i), 3'(7 - i), 6'(9 * i + 1)};

    @(negedge clk); @(negedge clk);
    check("reset_valid", bus.instr_valid, 0);
    check("reset_halted", halted, 0);
    check("reset_index", bus.mem_index, 0);
    #1 reset = 1'b0;

    // Start latency: valid on the third cycle after start is sampled.
    start = 1'b1;
    first = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.instr_valid && first == 0) first = c;
      #1 start = 1'b0;
      if (first != 0) break;
    end
    check("start_latency", first, 3);

    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        wait_valid();
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("hold_valid", bus.instr_valid, 1);
          check("hold_opcode", bus.instr_opcode, 3);
          check("hold_ra", bus.instr_ra, 4);
          check("hold_imm", bus.instr_imm, 28);
          check("hold_pc", bus.instr_pc, 3);
        end
        #1;
      end
      check("seq_opcode_next", 32'(i), 32'(i));
      accept(3'(i), 1'b0, 3'd0);
      if (i == 3) check("advance_by_one", bus.mem_index, 4);
    end
    check("halt_after_op7", halted, 1);

    // Restart from HALT, then abort with mem_load while in CAPT.
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk); #1;
    mem_load = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_valid", bus.instr_valid, 0);
    check("abort_index", bus.mem_index, 0);
    check("abort_halted", halted, 0);
    #1;
    for (int i = 0; i < 8; i++) mem[i] = 12'h000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("load_blocks_start", bus.instr_valid, 0);
      #1;
    end
    mem_load = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_load", bus.instr_valid, 0);
    end
    #1;

    // Program B: no HALT, pc wraps 7 -> 0.
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    for (int i = 0; i < 10; i++) accept(3'(i % 8), 1'b0, 3'd0);

    // Branch ignored without handshake, then taken on accept at pc=2.
    wait_valid();
    check("pre_branch_pc", bus.instr_pc, 2);
    bus.branch_valid = 1'b1; bus.branch_target = 3'd6;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("branch_no_ready", bus.mem_index, 2);
    end
    #1 bus.branch_valid = 1'b0;
    accept(3'd2, 1'b1, 3'd6);
    wait_valid();
    check("branch_target_pc", bus.instr_pc, 6);

    // Reset during ISSUE with a handshake and branch pending.
    reset = 1'b1; bus.instr_ready = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 3'd5;
    @(negedge clk);
    check("rst_issue_valid", bus.instr_valid, 0);
    check("rst_issue_index", bus.mem_index, 0);
    check("rst_issue_halted", halted, 0);
    #1 reset = 1'b0; bus.instr_ready = 1'b0; bus.branch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_reset", bus.instr_valid, 0);
      check("idle_after_reset_pc", bus.mem_index, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected before 200000");
    $fatal(1);
  end

endmodule
